// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM address, IF/ID register, fault detection
// Two-state control (RUN/FAULT); FAULT freezes every register until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 64,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  // 33 bits so a ROM covering the full 4 GiB space never truncates the limit to zero
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_next, instr_pc_next, fault_pc_next, fetch_count_next;
  logic        instr_valid_next;
  logic        out_of_range;

  assign imem_addr    = pc;
  assign fault        = (state == FAULT);
  assign out_of_range = CHECK_RANGE && ({1'b0, pc} >= PC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fault_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
      fault_pc    <= fault_pc_next;
      fetch_count <= fetch_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    fault_pc_next    = fault_pc;
    fetch_count_next = fetch_count;

    if (state == RUN) begin
      if (redirect) begin
        instr_next       = NOP;
        instr_valid_next = 1'b0;
        if (redirect_pc[1:0] == 2'b00) begin
          pc_next = redirect_pc;
        end else begin
          state_next    = FAULT;
          fault_pc_next = redirect_pc;
        end
      end else if (out_of_range) begin
        state_next       = FAULT;
        fault_pc_next    = pc;
        instr_next       = NOP;
        instr_valid_next = 1'b0;
      end else if (!stall) begin
        instr_next       = imem_rd;
        instr_pc_next    = pc;
        instr_valid_next = 1'b1;
        pc_next          = pc + 32'd4;
        fetch_count_next = fetch_count + 32'd1;
      end
    end
  end

endmodule
